ram_port_arb: RTL and testbench

Arbiter sharing the single-port fault-injection RAM between a functional host client and the background sweep engine (`barrido`). It sits between both requesters and the RAM's `mem_write_enable`/`mem_addr`/`mem_wdata`/`mem_rdata` port. It grants at most one access per cycle and gives the host priority, but an anti-starvation streak counter guarantees the sweep periodic slots. A lock input lets a sweep pass take the port exclusively. Per-requester read data is registered, and grant and stall statistics are kept.

---
 rtl/ram_port_arb.sv | 148 ++++++++++++++
 tb/tb_ram_port_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arb.sv
// Single-port RAM arbiter: the host client has priority, the sweep engine gets
// a guaranteed slot after MAX_HOST_BURST back-to-back host grants, and
// sweep_lock gives the sweep exclusive use of the port. Read data is
// registered per requester, and grant/stall statistics are kept.
module ram_port_arb #(
  parameter int N_WORDS        = 1 << 20,
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = $clog2(N_WORDS),
  parameter int MAX_HOST_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              sweep_req,
  input  logic              sweep_we,
  input  logic [ADDR_W-1:0] sweep_addr,
  input  logic [DATA_W-1:0] sweep_wdata,
  output logic              sweep_gnt,
  output logic              sweep_rvalid,
  output logic [DATA_W-1:0] sweep_rdata,
  input  logic              sweep_lock,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       host_grants,
  output logic [31:0]       sweep_grants,
  output logic [31:0]       host_stalls
);

  typedef enum logic [1:0] {IDLE, HOST, SWEEP, LOCKED} state_t;

  localparam logic [7:0] MAX_BURST = 8'(MAX_HOST_BURST);

  state_t      state_reg, state_next;
  logic [7:0]  streak_reg, streak_next;
  logic        host_rvalid_reg, sweep_rvalid_reg;

  // Grant decision: lock first, then anti-starvation slot, then host priority.
  always_comb begin
    state_next  = IDLE;
    host_gnt    = 1'b0;
    sweep_gnt   = 1'b0;
    streak_next = 8'd0;
    if (!reset) begin
      if (sweep_req && sweep_lock) begin
        sweep_gnt  = 1'b1;
        state_next = LOCKED;
      end else if (host_req && sweep_req && streak_reg == MAX_BURST) begin
        sweep_gnt  = 1'b1;
        state_next = SWEEP;
      end else if (host_req) begin
        host_gnt   = 1'b1;
        state_next = HOST;
      end else if (sweep_req) begin
        sweep_gnt  = 1'b1;
        state_next = SWEEP;
      end
      // The streak only counts host grants taken while the sweep is waiting.
      if (host_gnt && sweep_req) begin
        streak_next = streak_reg + 8'd1;
      end
    end
  end

  // Owner-of-previous-cycle and streak registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      streak_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
    end
  end

  // A cycle owned by the sweep always leaves the streak cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(state_reg inside {SWEEP, LOCKED}) || streak_reg == 8'd0);
    end
  end

  // RAM port mux: the granted requester drives the RAM, otherwise all zero.
  always_comb begin
    mem_write_enable = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    if (host_gnt) begin
      mem_write_enable = host_we;
      mem_addr         = host_addr;
      mem_wdata        = host_wdata;
    end else if (sweep_gnt) begin
      mem_write_enable = sweep_we;
      mem_addr         = sweep_addr;
      mem_wdata        = sweep_wdata;
    end
  end

  // Read return: capture RAM data on a granted read, pulse rvalid once.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_rvalid_reg  <= 1'b0;
      sweep_rvalid_reg <= 1'b0;
      host_rdata       <= '0;
      sweep_rdata      <= '0;
    end else begin
      host_rvalid_reg  <= host_gnt && !host_we;
      sweep_rvalid_reg <= sweep_gnt && !sweep_we;
      if (host_gnt && !host_we) begin
        host_rdata <= mem_rdata;
      end
      if (sweep_gnt && !sweep_we) begin
        sweep_rdata <= mem_rdata;
      end
    end
  end

  // A read return landing in a reset cycle is discarded.
  assign host_rvalid  = host_rvalid_reg && !reset;
  assign sweep_rvalid = sweep_rvalid_reg && !reset;

  // Saturating grant and stall statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_grants  <= '0;
      sweep_grants <= '0;
      host_stalls  <= '0;
    end else begin
      if (host_gnt && host_grants != 32'hFFFF_FFFF) begin
        host_grants <= host_grants + 32'd1;
      end
      if (sweep_gnt && sweep_grants != 32'hFFFF_FFFF) begin
        sweep_grants <= sweep_grants + 32'd1;
      end
      if (host_req && !host_gnt && host_stalls != 32'hFFFF_FFFF) begin
        host_stalls <= host_stalls + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arb.sv
// Bench for ram_port_arb: a 1K-word RAM with a stuck-at-1 word, a reference
// model of the arbitration rules and RAM contents, directed scenarios and a
// randomized run. Every cycle is compared on the falling clock edge.
module tb_ram_port_arb;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int MAXB   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_req, host_we, host_gnt, host_rvalid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic              sweep_req, sweep_we, sweep_gnt, sweep_rvalid, sweep_lock;
  logic [ADDR_W-1:0] sweep_addr;
  logic [DATA_W-1:0] sweep_wdata, sweep_rdata;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [31:0]       host_grants, sweep_grants, host_stalls;

  ram_port_arb #(.N_WORDS(1 << 20), .DATA_W(DATA_W), .MAX_HOST_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .sweep_req(sweep_req), .sweep_we(sweep_we), .sweep_addr(sweep_addr),
    .sweep_wdata(sweep_wdata), .sweep_gnt(sweep_gnt), .sweep_rvalid(sweep_rvalid),
    .sweep_rdata(sweep_rdata), .sweep_lock(sweep_lock),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .host_grants(host_grants), .sweep_grants(sweep_grants), .host_stalls(host_stalls)
  );

  always #5 clk = ~clk;

  // Word 0x003FF has its two low bits stuck at 1.
  function automatic logic [15:0] stuck(input logic [19:0] a);
    return (a == 20'h003FF) ? 16'h0003 : 16'h0000;
  endfunction

  // Environment RAM: 1K words, asynchronous read, write at the clock edge.
  logic [15:0] tb_ram [0:1023];
  logic        tb_init;
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) tb_ram[i] <= 16'h0000;
    end else if (mem_write_enable) begin
      tb_ram[mem_addr[9:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = tb_ram[mem_addr[9:0]] | stuck(mem_addr);

  // Reference model state.
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_run;
  logic        m_hrv, m_srv;
  logic [15:0] m_hrd, m_srd;
  logic [31:0] m_hg, m_sg, m_hs;
  logic [15:0] ref_mem [0:1023];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare DUT against the model on the falling edge, advance
  // the model, then return just after the next rising edge.
  task automatic step();
    logic        eh, es, ewe;
    logic [19:0] ea;
    logic [15:0] ed;
    @(negedge clk);
    eh = 1'b0;
    es = 1'b0;
    if (!reset) begin
      if (sweep_req && sweep_lock)                     es = 1'b1;
      else if (host_req && sweep_req && m_run == MAXB) es = 1'b1;
      else if (host_req)                               eh = 1'b1;
      else if (sweep_req)                              es = 1'b1;
    end
    ewe = eh ? host_we    : (es ? sweep_we    : 1'b0);
    ea  = eh ? host_addr  : (es ? sweep_addr  : 20'h0);
    ed  = eh ? host_wdata : (es ? sweep_wdata : 16'h0);
    chk("host_gnt", host_gnt, eh);
    chk("sweep_gnt", sweep_gnt, es);
    chk("mem_we", mem_write_enable, ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("host_rvalid", host_rvalid, m_hrv && !reset);
    chk("sweep_rvalid", sweep_rvalid, m_srv && !reset);
    chk("host_rdata", host_rdata, m_hrd);
    chk("sweep_rdata", sweep_rdata, m_srd);
    chk("host_grants", host_grants, m_hg);
    chk("sweep_grants", sweep_grants, m_sg);
    chk("host_stalls", host_stalls, m_hs);
    if (reset) begin
      m_run = 0; m_hrv = 0; m_srv = 0; m_hrd = 0; m_srd = 0;
      m_hg = 0; m_sg = 0; m_hs = 0;
    end else begin
      m_run = (eh && sweep_req) ? m_run + 1 : 0;
      m_hrv = eh && !host_we;
      m_srv = es && !sweep_we;
      if ((eh || es) && !ewe) begin
        if (eh) m_hrd = ref_mem[ea[9:0]] | stuck(ea);
        else    m_srd = ref_mem[ea[9:0]] | stuck(ea);
      end
      if ((eh || es) && ewe) ref_mem[ea[9:0]] = ed;
      if (eh) m_hg = m_hg + 1;
      if (es) m_sg = m_sg + 1;
      if (host_req && !eh) m_hs = m_hs + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_host(input logic r, input logic w, input logic [19:0] a, input logic [15:0] d);
    host_req = r; host_we = w; host_addr = a; host_wdata = d;
  endtask

  task automatic set_sweep(input logic r, input logic w, input logic [19:0] a, input logic [15:0] d,
                           input logic l);
    sweep_req = r; sweep_we = w; sweep_addr = a; sweep_wdata = d; sweep_lock = l;
  endtask

  task automatic do_reset();
    set_host(0, 0, 0, 0);
    set_sweep(0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
    m_run = 0; m_hrv = 0; m_srv = 0; m_hrd = 0; m_srd = 0;
    m_hg = 0; m_sg = 0; m_hs = 0;
    set_host(0, 0, 0, 0);
    set_sweep(0, 0, 0, 0, 0);
    reset   = 1'b1;
    tb_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tb_init = 1'b0;
    do_reset();
    chk("lit_reset_hg", host_grants, 32'd0);
    chk("lit_reset_rvalid", host_rvalid, 1'b0);

    // Host write then read of 0x00010.
    set_host(1, 1, 20'h00010, 16'hA5A5);
    step();
    set_host(1, 0, 20'h00010, 16'h0000);
    step();
    set_host(0, 0, 0, 0);
    chk("lit_h_rvalid", host_rvalid, 1'b1);
    chk("lit_h_rdata", host_rdata, 16'hA5A5);
    step();

    // Both requesting continuously: H,H,H,H,S repeating.
    do_reset();
    set_host(1, 0, 20'h00010, 0);
    set_sweep(1, 0, 20'h00020, 0, 0);
    for (int i = 0; i < 20; i++) begin
      chk("lit_pattern_s", sweep_gnt, (i % 5) == 4);
      step();
    end
    chk("lit_burst_hg", host_grants, 32'd16);
    chk("lit_burst_sg", sweep_grants, 32'd4);
    chk("model_burst_hg", m_hg, 32'd16);

    // Locked sweep for 10 cycles, then drop the lock.
    do_reset();
    set_host(1, 1, 20'h00030, 16'h1111);
    for (int i = 0; i < 10; i++) begin
      set_sweep(1, 0, 20'h00100 + 20'(i), 0, 1);
      #1;
      chk("lit_lock_addr", mem_addr, 20'h00100 + 20'(i));
      step();
    end
    chk("lit_lock_sg", sweep_grants, 32'd10);
    chk("lit_lock_hs", host_stalls, 32'd10);
    chk("model_lock_hs", m_hs, 32'd10);
    sweep_lock = 1'b0;
    #1;
    chk("lit_unlock_hgnt", host_gnt, 1'b1);
    step();

    // Reset in the cycle after a granted host read.
    set_sweep(0, 0, 0, 0, 0);
    set_host(1, 0, 20'h00010, 0);
    step();
    set_host(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("lit_rst_rvalid", host_rvalid, 1'b0);
    step();
    reset = 1'b0;
    chk("lit_rst_hg", host_grants, 32'd0);
    chk("lit_rst_sg", sweep_grants, 32'd0);
    chk("lit_rst_hs", host_stalls, 32'd0);
    set_host(1, 0, 20'h00010, 0);
    #1;
    chk("lit_post_rst_gnt", host_gnt, 1'b1);
    step();

    // Idle port: RAM lines at zero, counters frozen.
    for (int i = 0; i < 5; i++) begin
      set_host(0, 1, 20'(20'h00055 + i), 16'hBEEF);
      set_sweep(0, 1, 20'h00066, 16'hCAFE, 1);
      #1;
      chk("lit_idle_we", mem_write_enable, 1'b0);
      chk("lit_idle_addr", mem_addr, 20'h0);
      step();
    end
    chk("lit_idle_hg", host_grants, 32'd1);
    chk("lit_idle_sg", sweep_grants, 32'd0);

    // Sweep write 0 then read of the stuck word.
    set_sweep(1, 1, 20'h003FF, 16'h0000, 0);
    step();
    set_sweep(1, 0, 20'h003FF, 16'h0000, 0);
    step();
    set_sweep(0, 0, 0, 0, 0);
    chk("lit_stuck_rvalid", sweep_rvalid, 1'b1);
    chk("lit_stuck_rdata", sweep_rdata, 16'h0003);
    step();

    // Randomized traffic with occasional lock and reset.
    for (int i = 0; i < 3000; i++) begin
      logic [19:0] ha, sa;
      ha = ($urandom_range(0, 15) == 0) ? 20'h003FF : 20'($urandom_range(0, 63));
      sa = ($urandom_range(0, 15) == 0) ? 20'h003FF : 20'($urandom_range(0, 63));
      set_host($urandom_range(0, 3) != 0, 1'($urandom), ha, 16'($urandom));
      set_sweep($urandom_range(0, 2) == 0, 1'($urandom), sa, 16'($urandom),
                $urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    chk("model_run_bound", 32'(m_run <= MAXB), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
